fetch_stage: RTL and testbench

- Fetch stage of the 5-stage MIPS pipeline: PC register, PC+4 adder, next-PC select and the IF/ID pipeline register.
- Sits directly upstream of decode and the hazard unit.
- Consumes StallF/StallD from the hazard unit and the branch/jump redirect resolved in decode.
- Produces InstrD/PCPlus4D, which feed the RsD/RtD fields the hazard unit inspects.
- Also keeps saturating stall and flush counters for performance debug.

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : MIPS IF stage - PC register, next-PC select, IF/ID register and
//           saturating stall/flush counters.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic             JumpD,
  input  logic [31:0]      PCJumpD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic [31:0] redir_target;
  logic        redir;

  // A stalled decode has unresolved operands, so its branch/jump is ignored.
  assign redir        = ~StallD & (PCSrcD | JumpD);
  assign raw_target   = PCSrcD ? PCBranchD : PCJumpD;
  assign redir_target = {raw_target[31:2], 2'b00};
  assign pc_plus4     = PCF + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (redir) begin
      PCF <= redir_target;
    end else if (!StallF) begin
      PCF <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (redir || StallF) begin
      // Flush of the wrong-path fetch, or a bubble behind a held PC.
      InstrD   <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != CNT_MAX)) begin
        StallCount <= StallCount + 1'b1;
      end
      if (redir && (FlushCount != CNT_MAX)) begin
        FlushCount <= FlushCount + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0]      PCBranchD = '0, PCJumpD = '0;
  logic [31:0]      InstrF;
  logic [31:0]      PCF, InstrD, PCPlus4D;
  logic             ValidD;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h014B_4820;
    if (a == 32'h0040_0004) return 32'h012A_6020;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always_comb InstrF = imem(PCF);

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stalls, m_flushes;

  logic        t_redir;
  logic [31:0] t_tgt;
  always_comb begin
    t_redir = !StallD && (PCSrcD || JumpD);
    t_tgt   = (PCSrcD ? PCBranchD : PCJumpD) & 32'hFFFF_FFFC;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= RESET_PC; m_instr <= '0; m_pc4 <= '0; m_valid <= 1'b0;
      m_stalls <= 0; m_flushes <= 0;
    end else begin
      m_pc <= t_redir ? t_tgt : (StallF ? m_pc : m_pc + 32'd4);
      if (!StallD) begin
        if (t_redir || StallF) begin
          m_instr <= '0; m_pc4 <= '0; m_valid <= 1'b0;
        end else begin
          m_instr <= imem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
        end
      end
      m_stalls  <= m_stalls + (StallD ? 1 : 0);
      m_flushes <= m_flushes + (t_redir ? 1 : 0);
    end
  end

  function automatic logic [31:0] sat(input int v);
    return (v > CNT_SAT) ? 32'(CNT_SAT) : 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCF", PCF, m_pc);
      chk("InstrD", InstrD, m_instr);
      chk("PCPlus4D", PCPlus4D, m_pc4);
      chk("ValidD", 32'(ValidD), 32'(m_valid));
      chk("StallCount", 32'(StallCount), sat(m_stalls));
      chk("FlushCount", 32'(FlushCount), sat(m_flushes));
    end
  end

  task automatic step(input logic sf, input logic sd, input logic ps,
                      input logic [31:0] pb, input logic j, input logic [31:0] pj);
    StallF = sf; StallD = sd; PCSrcD = ps; PCBranchD = pb; JumpD = j; PCJumpD = pj;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_PCF"}, PCF, RESET_PC);
    chk({tag, "_InstrD"}, InstrD, 32'h0);
    chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
    chk({tag, "_ValidD"}, 32'(ValidD), 32'h0);
    chk({tag, "_StallCount"}, 32'(StallCount), 32'h0);
    chk({tag, "_FlushCount"}, 32'(FlushCount), 32'h0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    #1;
    chk_reset_vals("rst");

    // Sequential fetch
    step(0, 0, 0, '0, 0, '0);
    chk("seq1_PCF", PCF, 32'h0040_0004);
    chk("seq1_InstrD", InstrD, 32'h014B_4820);
    chk("seq1_PCPlus4D", PCPlus4D, 32'h0040_0004);
    chk("seq1_model_instr", m_instr, 32'h014B_4820);
    step(0, 0, 0, '0, 0, '0);
    chk("seq2_PCF", PCF, 32'h0040_0008);
    chk("seq2_InstrD", InstrD, 32'h012A_6020);
    chk("seq2_ValidD", 32'(ValidD), 32'h1);

    // Load-use stall for two cycles
    step(1, 1, 0, '0, 0, '0);
    step(1, 1, 0, '0, 0, '0);
    chk("stall_PCF", PCF, 32'h0040_0008);
    chk("stall_InstrD", InstrD, 32'h012A_6020);
    chk("stall_count", 32'(StallCount), 32'd2);
    step(0, 0, 0, '0, 0, '0);
    chk("resume_PCF", PCF, 32'h0040_000C);
    chk("resume_InstrD", InstrD, imem(32'h0040_0008));

    // Taken branch: one flushed slot, then target instruction
    step(0, 0, 1, 32'h0040_0100, 0, '0);
    chk("br_PCF", PCF, 32'h0040_0100);
    chk("br_InstrD", InstrD, 32'h0);
    chk("br_ValidD", 32'(ValidD), 32'h0);
    chk("br_flush", 32'(FlushCount), 32'd1);
    chk("br_model_pc", m_pc, 32'h0040_0100);
    step(0, 0, 0, '0, 0, '0);
    chk("br_tgt_InstrD", InstrD, imem(32'h0040_0100));

    // Branch beats jump
    step(0, 0, 1, 32'h0040_0180, 1, 32'h0040_0200);
    chk("both_PCF", PCF, 32'h0040_0180);
    chk("both_flush", 32'(FlushCount), 32'd2);
    // Branch under StallD is ignored
    step(1, 1, 1, 32'h0040_0300, 0, '0);
    chk("stalled_br_PCF", PCF, 32'h0040_0180);
    chk("stalled_br_flush", 32'(FlushCount), 32'd2);
    // Misaligned target is word-aligned
    step(0, 0, 1, 32'h0040_0103, 0, '0);
    chk("align_PCF", PCF, 32'h0040_0100);

    // Wrap-around of PC+4
    step(0, 0, 0, '0, 1, 32'hFFFF_FFFC);
    chk("jmp_top_PCF", PCF, 32'hFFFF_FFFC);
    step(0, 0, 0, '0, 0, '0);
    chk("wrap_PCF", PCF, 32'h0);
    chk("wrap_PCPlus4D", PCPlus4D, 32'h0);

    // Stall counter saturation
    repeat (14) step(1, 1, 0, '0, 0, '0);
    chk("sat_stall", 32'(StallCount), 32'hF);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      logic sd, sf, ps, jj;
      sd = ($urandom_range(0, 3) == 0);
      sf = sd ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      ps = ($urandom_range(0, 5) == 0);
      jj = ($urandom_range(0, 7) == 0);
      step(sf, sd, ps, $urandom, jj, $urandom);
    end

    // Asynchronous reset between edges while stalled
    step(1, 1, 0, '0, 0, '0);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    step(0, 0, 0, '0, 0, '0);
    chk("post_rst_PCF", PCF, 32'h0040_0004);
    chk("post_rst_InstrD", InstrD, 32'h014B_4820);
    repeat (20) step(0, 0, 0, '0, 0, '0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
